// File: rtl/counter_4bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_4bit: enable-gated modulo-(MAX+1) up-counter with terminal tick.  |
// | Build option: COUNTER_4BIT_SATURATE_EN (saturate at MAX, no wrap).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module counter_4bit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enable,
  output logic [WIDTH-1:0] io_count,
  output logic             io_tick
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_4bit: WIDTH must be in 1..32");
    end
    if (MAX < 1 || 64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("counter_4bit: MAX must be in 1..2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == c_max);
  assign io_count = r_count;

`ifdef COUNTER_4BIT_SATURATE_EN
  localparam logic [WIDTH-1:0] c_max_m1 = WIDTH'(MAX - 1);

  // Tick marks the single enabled edge that lands on MAX.
  assign io_tick = io_enable && (r_count == c_max_m1) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (io_enable && !w_at_max) begin
      r_count <= r_count + c_one;
    end
  end
`else
  assign io_tick = io_enable && w_at_max && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (io_enable) begin
      r_count <= w_at_max ? '0 : (r_count + c_one);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_4bit.sv
`default_nettype none
// Scoreboard bench for counter_4bit: expected counts queued at drive time,
// popped and compared after each rising edge.
module tb_counter_4bit;

  localparam int MAXV = 15;
`ifdef COUNTER_4BIT_SATURATE_EN
  localparam int TICK_AT = MAXV - 1;
  localparam bit SAT = 1'b1;
`else
  localparam int TICK_AT = MAXV;
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_enable = 1'b0;
  logic [3:0] io_count;
  logic       io_tick;

  int n_checks = 0;
  int n_errors = 0;
  int m_count  = 0;
  int exp_q[$];

  counter_4bit #(.WIDTH(4), .MAX(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_enable (io_enable),
    .io_count  (io_count),
    .io_tick   (io_tick)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_value(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int model_next(input int c, input logic en, input logic rst);
    if (rst) return 0;
    if (!en) return c;
    if (c == MAXV) return SAT ? MAXV : 0;
    return c + 1;
  endfunction

  // Called at a negedge: drive enable, check tick, queue expected count, take one edge.
  task automatic step(input logic en);
    int nxt;
    io_enable = en;
    #1;
    check_value("tick", int'(io_tick), int'(!reset && en && (m_count == TICK_AT)));
    nxt = model_next(m_count, en, reset);
    exp_q.push_back(nxt);
    m_count = nxt;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) check_value("queue_empty", 1, 0);
    else check_value("count", int'(io_count), exp_q.pop_front());
    @(negedge clock);
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    check_value("async_rst_count", int'(io_count), 0);
    check_value("async_rst_tick", int'(io_tick), 0);
    m_count = 0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_value("reset_count", int'(io_count), 0);
    check_value("reset_tick", int'(io_tick), 0);
    @(negedge clock);
    // Reset held for two edges with enable low.
    for (int i = 0; i < 2; i++) step(1'b0);
    reset = 1'b0;
    step(1'b0);                               // idle after reset
    for (int i = 0; i < 3; i++) step(1'b1);   // count to 3
    async_reset_check();                      // reset between edges
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1);  // full wrap (saturates in sat build)
    if (!SAT) begin
      for (int i = 0; i < 5; i++) step(1'b0); // hold at 4
      for (int i = 0; i < 11; i++) step(1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0);   // hold at terminal
    step(1'b1);                               // re-enable: tick then wrap
    for (int i = 0; i < 6; i++) step(logic'(i % 2 == 0)); // toggling enable
    while (m_count != MAXV) step(1'b1);
    io_enable = 1'b1;
    #1;
    check_value("tick_at_max", int'(io_tick), int'(TICK_AT == MAXV));
    async_reset_check();                      // reset at MAX
    @(negedge clock);
    step(1'b1);                               // still in reset
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
